// File: rtl/ros_seq_pkg.sv
// Shared constants and state encoding for the ring-oscillator measurement sequencer.
// Every state spends at least one cycle; timed states reload ros_seq_timer on entry.
package ros_seq_pkg;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_CLEAR  = 3'd1,
        S_GATE   = 3'd2,
        S_LATCH  = 3'd3,
        S_SEND   = 3'd4,
        S_SHIFT  = 3'd5,
        S_FINISH = 3'd6
    } state_t;

    localparam int HOLD_CYCLES    = 4;
    localparam int SEND_CYCLES    = 4;
    localparam int FRAME_HDR_BITS = 4;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/ros_seq_timer.sv
// Loadable down-counter shared by all timed sequencer states.
// Loading N makes zero assert N edges later, so a state lasts N+1 cycles.
module ros_seq_timer
    import ros_seq_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    output logic             zero
);

    logic [WIDTH-1:0] count;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (load) begin
            count <= load_value;
        end else if (count != '0) begin
            count <= count - WIDTH'(1);
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/ros_measure_sequencer.sv
// Clear / gate / latch / readout sequencer for the ring-oscillator counter array.
// Optional continuous re-run is enabled by defining ROS_SEQ_AUTO_REPEAT_EN.
module ros_measure_sequencer
    import ros_seq_pkg::*;
#(
    parameter int COUNTER_LENGTH = 20,
    parameter int GATE_WIDTH     = 16,
    parameter int NUM_ROS        = 3
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [GATE_WIDTH-1:0] gate_cycles,
    input  logic [NUM_ROS-1:0]    ro_mask,
    input  logic                  repeat_mode,
    output logic                  busy,
    output logic                  done,
    output logic                  ctr_reset,
    output logic                  latch_counter,
    output logic                  send_counter,
    output logic [1:0]            counter_select,
    output logic                  frame_active
);

    localparam int TW = max_int(GATE_WIDTH, $clog2(COUNTER_LENGTH + 5));

    state_t                state;
    state_t                nxt;
    logic [GATE_WIDTH-1:0] gate_cfg;
    logic [NUM_ROS-1:0]    mask_cfg;
    logic                  rep_run;
    logic                  fin_rep;

    logic                  tmr_load;
    logic [TW-1:0]         tmr_value;
    logic                  tmr_zero;

    logic                  hit;
    logic [1:0]            hit_idx;
    logic [2:0]            search_from;

`ifdef ROS_SEQ_AUTO_REPEAT_EN
    assign fin_rep = repeat_mode;
`else
    logic unused_repeat;
    assign unused_repeat = repeat_mode;
    assign fin_rep       = 1'b0;
`endif

    ros_seq_timer #(.WIDTH(TW)) u_timer (
        .clk        (clk),
        .reset      (reset),
        .load       (tmr_load),
        .load_value (tmr_value),
        .zero       (tmr_zero)
    );

    // Lowest enabled oscillator at or above search_from; during SHIFT this is the next frame.
    always_comb begin
        search_from = (state == S_SHIFT) ? ({1'b0, counter_select} + 3'd1) : 3'd0;
        hit         = 1'b0;
        hit_idx     = 2'd0;
        for (int i = NUM_ROS - 1; i >= 0; i--) begin
            if (mask_cfg[i] && (3'(i) >= search_from)) begin
                hit     = 1'b1;
                hit_idx = 2'(i);
            end
        end
    end

    always_comb begin
        nxt       = state;
        tmr_load  = 1'b0;
        tmr_value = '0;
        case (state)
            S_IDLE: begin
                if (start) begin
                    nxt       = S_CLEAR;
                    tmr_load  = 1'b1;
                    tmr_value = TW'(HOLD_CYCLES - 1);
                end
            end
            S_CLEAR: begin
                if (tmr_zero) begin
                    tmr_load = 1'b1;
                    if (gate_cfg == '0) begin
                        nxt       = S_LATCH;
                        tmr_value = TW'(HOLD_CYCLES - 1);
                    end else begin
                        nxt       = S_GATE;
                        tmr_value = TW'(gate_cfg) - TW'(1);
                    end
                end
            end
            S_GATE: begin
                if (tmr_zero) begin
                    nxt       = S_LATCH;
                    tmr_load  = 1'b1;
                    tmr_value = TW'(HOLD_CYCLES - 1);
                end
            end
            S_LATCH, S_SHIFT: begin
                if (tmr_zero) begin
                    if (hit) begin
                        nxt       = S_SEND;
                        tmr_load  = 1'b1;
                        tmr_value = TW'(SEND_CYCLES - 1);
                    end else begin
                        nxt = S_FINISH;
                    end
                end
            end
            S_SEND: begin
                if (tmr_zero) begin
                    nxt       = S_SHIFT;
                    tmr_load  = 1'b1;
                    tmr_value = TW'(COUNTER_LENGTH + FRAME_HDR_BITS - 1);
                end
            end
            S_FINISH: begin
                if (rep_run) begin
                    nxt       = S_CLEAR;
                    tmr_load  = 1'b1;
                    tmr_value = TW'(HOLD_CYCLES - 1);
                end else begin
                    nxt = S_IDLE;
                end
            end
            default: nxt = S_IDLE;
        endcase
    end

    // Outputs are decoded from the next state so they change on the same edge as the state.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state          <= S_IDLE;
            gate_cfg       <= '0;
            mask_cfg       <= '0;
            rep_run        <= 1'b0;
            busy           <= 1'b0;
            done           <= 1'b0;
            ctr_reset      <= 1'b0;
            latch_counter  <= 1'b0;
            send_counter   <= 1'b0;
            frame_active   <= 1'b0;
            counter_select <= 2'd0;
        end else begin
            state <= nxt;
            if (state == S_IDLE && start) begin
                gate_cfg <= gate_cycles;
                mask_cfg <= ro_mask;
            end
            if (nxt == S_FINISH) begin
                rep_run <= fin_rep;
            end
            busy          <= (nxt == S_FINISH) ? fin_rep : (nxt != S_IDLE);
            done          <= (nxt == S_FINISH);
            ctr_reset     <= (nxt == S_CLEAR);
            latch_counter <= (nxt == S_LATCH);
            send_counter  <= (nxt == S_SEND);
            frame_active  <= (nxt == S_SHIFT);
            if (nxt == S_SEND && state != S_SEND) begin
                counter_select <= hit_idx;
            end
        end
    end

endmodule

// File: doc/ros_measure_sequencer.md
# ros_measure_sequencer

Measurement controller for the ring-oscillator frequency-measurement array. It drives the shared `ctr_reset`, `latch_counter`, `send_counter` and `counter_select` controls of the three oscillator counters and the Manchester readout shift register from a single `start` pulse. One start runs this sequence:

- clear all counters
- count a programmable gate window of `clk` cycles
- latch the counters
- stream one readout frame for each oscillator enabled in a mask

It sits between the pin-level control inputs and the oscillator/readout datapath.

## Interface
Parameters:
- `COUNTER_LENGTH`, 20: counter width. A readout frame lasts `COUNTER_LENGTH`+4 `clk` cycles (4-bit header followed by the count).
- `GATE_WIDTH`, 16: width of the gate-window length.
- `NUM_ROS`, 3: number of oscillators. Must be ≤4, because `counter_select` is 2 bits.

Ports:
- `clk`, in, 1: sole clock.
- `reset`, in, 1: asynchronous, active-high reset.
- `start`, in, 1: one-cycle request; sampled on the rising edge of `clk`.
- `gate_cycles`, in, `GATE_WIDTH`: gate window length in `clk` cycles; captured at start.
- `ro_mask`, in, `NUM_ROS`: oscillators to read out (bit i selects oscillator i); captured at start.
- `repeat_mode`, in, 1: continuous mode request (see Configuration).
- `busy`, out, 1: a sequence is in progress.
- `done`, out, 1: one-cycle pulse at the end of a sequence.
- `ctr_reset`, out, 1: counter clear.
- `latch_counter`, out, 1: counter latch.
- `send_counter`, out, 1: readout load request.
- `counter_select`, out, 2: oscillator index presented to the readout.
- `frame_active`, out, 1: a readout frame is currently being shifted out.

## Operation
- FSM states: IDLE, CLEAR, GATE, LATCH, SEND, SHIFT, FINISH.
- IDLE
  - `start`=1 → capture `gate_cycles` and `ro_mask` → CLEAR.
  - `start` in any other state is ignored.
- CLEAR: `ctr_reset`=1 for `HOLD_CYCLES`=4 cycles, which covers the 3-stage synchronisers in the oscillator domains. Then → GATE.
- GATE: all control outputs low for `gate_cycles` cycles. `gate_cycles`=0 skips GATE entirely (CLEAR → LATCH).
- LATCH: `latch_counter`=1 for 4 cycles. Then select the lowest set bit of the captured mask:
  - if one exists → SEND;
  - if the mask is zero → FINISH.
- SEND: `send_counter`=1 for 4 cycles (3 sync stages plus 1 load), with `counter_select` = current index. Then → SHIFT.
- SHIFT: `send_counter`=0 and `frame_active`=1 for `COUNTER_LENGTH`+4 cycles. Then either:
  - the next higher set mask bit exists → SEND;
  - otherwise → FINISH.
- FINISH: `done`=1 and `busy`=0 for one cycle. Then → IDLE.
- `counter_select` holds its last value outside SEND/SHIFT.
- Mask bits at or above `NUM_ROS` do not exist. Index 3 is never selected when `NUM_ROS`=3.
- Captured configuration is immune to changes on the input pins mid-sequence.
- Async `reset` in any state:
  - immediately forces IDLE;
  - all outputs 0, `counter_select`=0;
  - clears the timer.

## Timing
- All outputs are registered and driven directly from state/timer flops. There are no combinational paths from inputs to outputs.
- `start` sampled at edge k → `busy`=1 and `ctr_reset`=1 from cycle k+1.
- Sequence length T = 4 + `gate_cycles` + 4 + n·(8+`COUNTER_LENGTH`), where n = popcount of the mask. `done` pulses at cycle k+1+T.
- `latch_counter` rises exactly `gate_cycles` cycles after `ctr_reset` falls.
- Between frames, `send_counter` rises in the first cycle after the previous SHIFT ends. There is no idle gap.

## Configuration
- Macro: `ROS_SEQ_AUTO_REPEAT_EN`.
- Defined: if `repeat_mode`=1 when FINISH is reached:
  - `done` still pulses;
  - `busy` stays 1;
  - the next state is CLEAR, re-using the captured configuration.
  - Deasserting `repeat_mode` stops the loop after the current sequence.
- Undefined: `repeat_mode` is ignored and FINISH always → IDLE.

## Structure
- Shared package `ros_seq_pkg` holds:
  - the state encoding;
  - `HOLD_CYCLES`=4 and `SEND_CYCLES`=4;
  - the header width constant `FRAME_HDR_BITS`=4.
- One sub-module, `ros_seq_timer`: a loadable down-counter with a `zero` flag, sized to max(`GATE_WIDTH`, clog2(`COUNTER_LENGTH`+5)). It is shared by all timed states.

## Test plan
- **Full sequence:** `gate_cycles`=10, `ro_mask`=3'b111, `start` at k → `ctr_reset` high k+1..k+4, `latch_counter` high k+15..k+18, three 4-cycle `send_counter` pulses with `counter_select`=0,1,2 at 28-cycle spacing, `done` at k+103.
- **Sparse mask:** `ro_mask`=3'b100 → only `counter_select`=2 is sent. `ro_mask`=0 → `done` at k+9 (with `gate_cycles`=0) and no `send_counter` activity.
- **Ignored start:** `start` pulsed mid-GATE and mid-SHIFT, and `gate_cycles` changed mid-run → timing identical to the first scenario.
- **Mid-operation reset:** `reset` asserted in SHIFT → all outputs 0 asynchronously, before the next edge. Then `start` after release → a clean full sequence.
- **Auto-repeat (macro defined):** `repeat_mode`=1 → `done` pulses every 103 cycles with `busy` held high. `repeat_mode` cleared → IDLE after the next `done`. With the macro undefined → a single run only.
- **Zero gate:** `gate_cycles`=0 → `latch_counter` rises in the cycle immediately after `ctr_reset` falls.
